// File: rtl/uart_frame_tx_fifo_module_if.sv
// Upstream-facing bundle of the framed UART transmitter: word handshake,
// break request, status outputs and the serial pin.
interface uart_frame_tx_fifo_module_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ready;
    logic                 tx_break;
    logic                 tx_busy;
    logic [FIFO_AW:0]     tx_level;
    logic                 tx_done;
    logic                 tx_pin;

    modport master (
        output tx_data, tx_data_valid, tx_break,
        input  tx_data_ready, tx_busy, tx_level, tx_done, tx_pin
    );

    modport slave (
        input  tx_data, tx_data_valid, tx_break,
        output tx_data_ready, tx_busy, tx_level, tx_done, tx_pin
    );
endinterface

// File: rtl/uart_frame_tx_fifo_module.sv
// Framed UART transmitter with an input FIFO. Configurable data width,
// parity and stop bits; frames leave back-to-back separated by the single
// S_LOAD clock. A break request holds the line low while idle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | line high, waiting for a FIFO word or a break request
//   S_BREAK  | line held low while tx_break stays high
//   S_LOAD   | one clock: pop FIFO head into the shift latch, form parity
//   S_START  | start bit, line low for CYCLE clocks
//   S_DATA   | DATA_BITS data bits, LSB first, CYCLE clocks each
//   S_PARITY | parity bit (never entered when PARITY = 0)
//   S_STOP   | STOP_BITS stop bits, tx_done on the very last clock
module uart_frame_tx_fifo_module #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input logic                        clk,
    input logic                        rst_n,
    uart_frame_tx_fifo_module_if.slave bus
);
    localparam int          CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int          DEPTH     = 2 ** FIFO_AW;
    localparam int          PTR_W     = FIFO_AW + 1;
    localparam logic [15:0] CYC_LAST  = 16'(CYCLE - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_next;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr_next, rd_next;
    logic                 ready_q;
    logic                 wr_en, rd_en;
    logic                 fifo_empty, full_next;
    logic [DATA_BITS-1:0] head;

    logic [15:0]          cyc_cnt, cyc_next;
    logic [3:0]           bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift_q, shift_next;
    logic                 parity_q, parity_next;
    logic                 pin_q, pin_next;
    logic                 done_c;
    logic                 cyc_end;

    assign wr_en      = bus.tx_data_valid && ready_q;
    assign rd_en      = (state == S_LOAD);
    assign wr_next    = wr_ptr + PTR_W'(wr_en);
    assign rd_next    = rd_ptr + PTR_W'(rd_en);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];

    // Ready looks at the post-edge pointers so a write can never land on a full FIFO.
    assign full_next  = (wr_next[FIFO_AW] != rd_next[FIFO_AW]) &&
                        (wr_next[FIFO_AW-1:0] == rd_next[FIFO_AW-1:0]);

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= bus.tx_data;
        end
    end

    // FIFO pointers and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            ready_q <= !full_next;
        end
    end

    assign cyc_end = (cyc_cnt == CYC_LAST);

    // Next-state, counter and shift logic; tx_pin is derived from the next state.
    always_comb begin
        state_next  = state;
        cyc_next    = cyc_cnt + 16'd1;
        bit_next    = bit_cnt;
        shift_next  = shift_q;
        parity_next = parity_q;
        done_c      = 1'b0;

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_LOAD;
                end else if (bus.tx_break) begin
                    state_next = S_BREAK;
                end
            end
            S_BREAK: begin
                if (!bus.tx_break) begin
                    state_next = S_IDLE;
                end
            end
            S_LOAD: begin
                shift_next  = head;
                parity_next = (PARITY == 1) ? ~^head : ^head;
                bit_next    = 4'd0;
                state_next  = S_START;
            end
            S_START: begin
                if (cyc_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (cyc_end) begin
                    cyc_next = 16'd0;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = 4'd0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next   = bit_cnt + 4'd1;
                        shift_next = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (cyc_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (cyc_end) begin
                    cyc_next = 16'd0;
                    if (bit_cnt == STOP_LAST) begin
                        done_c     = 1'b1;
                        bit_next   = 4'd0;
                        state_next = fifo_empty ? S_IDLE : S_LOAD;
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (state_next != state) begin
            cyc_next = 16'd0;
        end

        case (state_next)
            S_BREAK,
            S_START:  pin_next = 1'b0;
            S_DATA:   pin_next = shift_next[0];
            S_PARITY: pin_next = parity_next;
            default:  pin_next = 1'b1;
        endcase
    end

    // State, counters, shift latch and the registered serial output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cyc_cnt  <= 16'd0;
            bit_cnt  <= 4'd0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            pin_q    <= 1'b1;
        end else begin
            state    <= state_next;
            cyc_cnt  <= cyc_next;
            bit_cnt  <= bit_next;
            shift_q  <= shift_next;
            parity_q <= parity_next;
            pin_q    <= pin_next;
        end
    end

    assign bus.tx_data_ready = ready_q;
    assign bus.tx_busy       = (state != S_IDLE) || !fifo_empty;
    assign bus.tx_level      = wr_ptr - rd_ptr;
    assign bus.tx_done       = done_c;
    assign bus.tx_pin        = pin_q;
endmodule

// File: tb/tb_uart_frame_tx_fifo_module.sv
// Directed bench for the framed UART transmitter. Four instances cover
// 8N1, 7O2, 8E1 and a depth-4 FIFO; all run at CYCLE = 10 clocks per bit.
module tb_uart_frame_tx_fifo_module;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_frame_tx_fifo_module_if #(.DATA_BITS(8), .FIFO_AW(4)) if0 ();
    uart_frame_tx_fifo_module_if #(.DATA_BITS(7), .FIFO_AW(4)) if1 ();
    uart_frame_tx_fifo_module_if #(.DATA_BITS(8), .FIFO_AW(4)) if2 ();
    uart_frame_tx_fifo_module_if #(.DATA_BITS(8), .FIFO_AW(2)) if3 ();

    uart_frame_tx_fifo_module #(.CLK_FRE(50), .BAUD_RATE(5000000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_AW(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    uart_frame_tx_fifo_module #(.CLK_FRE(50), .BAUD_RATE(5000000), .DATA_BITS(7),
        .PARITY(1), .STOP_BITS(2), .FIFO_AW(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    uart_frame_tx_fifo_module #(.CLK_FRE(50), .BAUD_RATE(5000000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_AW(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    uart_frame_tx_fifo_module #(.CLK_FRE(50), .BAUD_RATE(5000000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    int   n_cmp;
    int   n_fail;
    logic rec_pin  [0:1023];
    logic rec_done [0:1023];

    function automatic logic pin_of(input int sel);
        case (sel)
            0:       return if0.tx_pin;
            1:       return if1.tx_pin;
            2:       return if2.tx_pin;
            default: return if3.tx_pin;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return if0.tx_done;
            1:       return if1.tx_done;
            2:       return if2.tx_done;
            default: return if3.tx_done;
        endcase
    endfunction

    // Records pin/done of one instance at each falling edge, index j = clocks after the write edge.
    task automatic capture(input int sel, input int from, input int to);
        for (int j = from; j <= to; j++) begin
            @(negedge clk);
            rec_pin[j]  = pin_of(sel);
            rec_done[j] = done_of(sel);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (if0.tx_pin !== 1'b1) begin n_fail++; $display("FAIL rst_pin: got %b want 1", if0.tx_pin); end
        n_cmp++; if (if0.tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", if0.tx_data_ready); end
        n_cmp++; if (if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", if0.tx_busy); end
        n_cmp++; if (if0.tx_level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", if0.tx_level); end
        n_cmp++; if (if0.tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", if0.tx_done); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (if0.tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL ready_at_release: got %b want 0", if0.tx_data_ready); end
        @(negedge clk);
        n_cmp++; if (if0.tx_data_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", if0.tx_data_ready); end
        n_cmp++; if (if3.tx_data_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge_u3: got %b want 1", if3.tx_data_ready); end
    endtask

    task automatic test_8n1();
        logic [9:0] fb;
        int bad, dn;
        fb = {1'b1, 8'hA5, 1'b0};
        if0.tx_data = 8'hA5; if0.tx_data_valid = 1'b1;
        @(negedge clk);
        if0.tx_data_valid = 1'b0;
        n_cmp++; if (if0.tx_level !== 5'd1) begin n_fail++; $display("FAIL 8n1_level_after_write: got %0d want 1", if0.tx_level); end
        n_cmp++; if (if0.tx_busy !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy: got %b want 1", if0.tx_busy); end
        capture(0, 1, 110);
        n_cmp++; if (rec_pin[1] !== 1'b1) begin n_fail++; $display("FAIL 8n1_load_high: got %b want 1", rec_pin[1]); end
        for (int c = 0; c < 10; c++) begin
            bad = 0;
            for (int s = 0; s < 10; s++) if (rec_pin[2 + 10*c + s] !== fb[c]) bad++;
            n_cmp++;
            if (bad != 0) begin n_fail++; $display("FAIL 8n1_bit%0d: got %b want %b (%0d clocks wrong)", c, rec_pin[2 + 10*c + 5], fb[c], bad); end
        end
        dn = 0;
        for (int j = 1; j <= 110; j++) dn += int'(rec_done[j]);
        n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL 8n1_done_count: got %0d want 1", dn); end
        n_cmp++; if (rec_done[101] !== 1'b1) begin n_fail++; $display("FAIL 8n1_done_pos: got %b want 1 at frame clock 100", rec_done[101]); end
        n_cmp++; if (rec_pin[102] !== 1'b1) begin n_fail++; $display("FAIL 8n1_idle_after: got %b want 1", rec_pin[102]); end
        n_cmp++; if (if0.tx_busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_end: got %b want 0", if0.tx_busy); end
    endtask

    task automatic test_7o2();
        logic [10:0] fb;
        int bad, dn;
        fb = {2'b11, 1'b1, 7'h55, 1'b0};
        if1.tx_data = 7'h55; if1.tx_data_valid = 1'b1;
        @(negedge clk);
        if1.tx_data_valid = 1'b0;
        capture(1, 1, 120);
        for (int c = 0; c < 11; c++) begin
            bad = 0;
            for (int s = 0; s < 10; s++) if (rec_pin[2 + 10*c + s] !== fb[c]) bad++;
            n_cmp++;
            if (bad != 0) begin n_fail++; $display("FAIL 7o2_bit%0d: got %b want %b (%0d clocks wrong)", c, rec_pin[2 + 10*c + 5], fb[c], bad); end
        end
        dn = 0;
        for (int j = 1; j <= 120; j++) dn += int'(rec_done[j]);
        n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL 7o2_done_count: got %0d want 1", dn); end
        n_cmp++; if (rec_done[111] !== 1'b1) begin n_fail++; $display("FAIL 7o2_done_pos: got %b want 1 at frame clock 110", rec_done[111]); end
        n_cmp++; if (rec_pin[112] !== 1'b1) begin n_fail++; $display("FAIL 7o2_idle_after: got %b want 1", rec_pin[112]); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] fa, fz;
        int bad, dn;
        fa = {1'b1, 1'b0, 8'h03, 1'b0};
        fz = {1'b1, 1'b1, 8'h07, 1'b0};
        if2.tx_data = 8'h03; if2.tx_data_valid = 1'b1;
        @(negedge clk);
        if2.tx_data = 8'h07;
        @(negedge clk);
        if2.tx_data_valid = 1'b0;
        rec_pin[1] = if2.tx_pin; rec_done[1] = if2.tx_done;
        capture(2, 2, 230);
        for (int c = 0; c < 11; c++) begin
            bad = 0;
            for (int s = 0; s < 10; s++) if (rec_pin[2 + 10*c + s] !== fa[c]) bad++;
            n_cmp++;
            if (bad != 0) begin n_fail++; $display("FAIL b2b_f1_bit%0d: got %b want %b (%0d clocks wrong)", c, rec_pin[2 + 10*c + 5], fa[c], bad); end
        end
        n_cmp++; if (rec_pin[112] !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got %b want 1", rec_pin[112]); end
        for (int c = 0; c < 11; c++) begin
            bad = 0;
            for (int s = 0; s < 10; s++) if (rec_pin[113 + 10*c + s] !== fz[c]) bad++;
            n_cmp++;
            if (bad != 0) begin n_fail++; $display("FAIL b2b_f2_bit%0d: got %b want %b (%0d clocks wrong)", c, rec_pin[113 + 10*c + 5], fz[c], bad); end
        end
        dn = 0;
        for (int j = 1; j <= 230; j++) dn += int'(rec_done[j]);
        n_cmp++; if (dn != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", dn); end
        n_cmp++; if (rec_done[111] !== 1'b1 || rec_done[222] !== 1'b1) begin n_fail++; $display("FAIL b2b_done_pos: got %b%b want 11", rec_done[111], rec_done[222]); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] wv [6];
        logic [7:0] got [8];
        logic [7:0] w;
        int idx, nw, dn, bad_rdy, max_lvl, j;
        logic r_prev, rdy_low_seen;
        wv[0] = 8'h01; wv[1] = 8'h80; wv[2] = 8'hFF; wv[3] = 8'h00; wv[4] = 8'h5A; wv[5] = 8'hC3;
        idx = 0; dn = 0; bad_rdy = 0; max_lvl = 0; rdy_low_seen = 1'b0;
        if3.tx_data = wv[0]; if3.tx_data_valid = 1'b1;
        r_prev = if3.tx_data_ready;
        for (int k = 1; k <= 720; k++) begin
            @(negedge clk);
            if (if3.tx_data_valid && r_prev) begin
                idx++;
                if (idx < 6) if3.tx_data = wv[idx];
                else if3.tx_data_valid = 1'b0;
            end
            r_prev = if3.tx_data_ready;
            rec_pin[k] = if3.tx_pin;
            dn += int'(if3.tx_done);
            if (int'(if3.tx_level) > max_lvl) max_lvl = int'(if3.tx_level);
            if (if3.tx_data_ready !== (if3.tx_level != 3'd4)) bad_rdy++;
            if (if3.tx_data_ready === 1'b0) rdy_low_seen = 1'b1;
        end
        n_cmp++; if (idx != 6) begin n_fail++; $display("FAIL fifo_all_accepted: got %0d want 6", idx); end
        n_cmp++; if (max_lvl != 4) begin n_fail++; $display("FAIL fifo_max_level: got %0d want 4", max_lvl); end
        n_cmp++; if (rdy_low_seen !== 1'b1) begin n_fail++; $display("FAIL fifo_ready_dropped: got %b want 1", rdy_low_seen); end
        n_cmp++; if (bad_rdy != 0) begin n_fail++; $display("FAIL fifo_ready_vs_level: got %0d bad clocks want 0", bad_rdy); end
        nw = 0; j = 1;
        while (j < 620) begin
            if (rec_pin[j] === 1'b0 && nw < 8) begin
                for (int b = 0; b < 8; b++) w[b] = rec_pin[j + 10*(b+1) + 5];
                got[nw] = w;
                nw++;
                j += 100;
            end else begin
                j++;
            end
        end
        n_cmp++; if (nw != 6) begin n_fail++; $display("FAIL fifo_frame_count: got %0d want 6", nw); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= nw || got[i] !== wv[i]) begin n_fail++; $display("FAIL fifo_word%0d: got %h want %h", i, (i < nw) ? got[i] : 8'hxx, wv[i]); end
        end
        n_cmp++; if (dn != 6) begin n_fail++; $display("FAIL fifo_done_count: got %0d want 6", dn); end
        n_cmp++; if (if3.tx_level !== 3'd0) begin n_fail++; $display("FAIL fifo_level_end: got %0d want 0", if3.tx_level); end
        n_cmp++; if (if3.tx_busy !== 1'b0) begin n_fail++; $display("FAIL fifo_busy_end: got %b want 0", if3.tx_busy); end
    endtask

    task automatic test_break();
        logic [9:0] fb;
        int bad, dn;
        fb = {1'b1, 8'h3C, 1'b0};
        if0.tx_break = 1'b1;
        for (int j = 1; j <= 165; j++) begin
            @(negedge clk);
            rec_pin[j]  = if0.tx_pin;
            rec_done[j] = if0.tx_done;
            if (j == 20) begin if0.tx_data = 8'h3C; if0.tx_data_valid = 1'b1; end
            if (j == 21) if0.tx_data_valid = 1'b0;
            if (j == 25) begin
                n_cmp++; if (if0.tx_level !== 5'd1) begin n_fail++; $display("FAIL brk_level_mid: got %0d want 1", if0.tx_level); end
            end
            if (j == 50) if0.tx_break = 1'b0;
        end
        bad = 0;
        for (int j = 1; j <= 50; j++) if (rec_pin[j] !== 1'b0) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL brk_low: got %0d high clocks want 0", bad); end
        n_cmp++; if (rec_pin[51] !== 1'b1 || rec_pin[52] !== 1'b1) begin n_fail++; $display("FAIL brk_release: got %b%b want 11", rec_pin[51], rec_pin[52]); end
        for (int c = 0; c < 10; c++) begin
            bad = 0;
            for (int s = 0; s < 10; s++) if (rec_pin[53 + 10*c + s] !== fb[c]) bad++;
            n_cmp++;
            if (bad != 0) begin n_fail++; $display("FAIL brk_word_bit%0d: got %b want %b (%0d clocks wrong)", c, rec_pin[53 + 10*c + 5], fb[c], bad); end
        end
        dn = 0;
        for (int j = 1; j <= 165; j++) dn += int'(rec_done[j]);
        n_cmp++; if (dn != 1 || rec_done[152] !== 1'b1) begin n_fail++; $display("FAIL brk_done: got count %0d pos %b want 1 and 1", dn, rec_done[152]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] fb;
        int bad, dn;
        fb = {1'b1, 8'h5A, 1'b0};
        if0.tx_data = 8'h00; if0.tx_data_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if0.tx_data_valid = 1'b0;
        repeat (39) @(negedge clk);
        n_cmp++; if (if0.tx_pin !== 1'b0) begin n_fail++; $display("FAIL rmid_in_data: got %b want 0", if0.tx_pin); end
        n_cmp++; if (if0.tx_level !== 5'd1) begin n_fail++; $display("FAIL rmid_level_before: got %0d want 1", if0.tx_level); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (if0.tx_pin !== 1'b1) begin n_fail++; $display("FAIL rmid_pin: got %b want 1", if0.tx_pin); end
        n_cmp++; if (if0.tx_level !== 5'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", if0.tx_level); end
        n_cmp++; if (if0.tx_busy !== 1'b0 || if0.tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_ready: got %b%b want 00", if0.tx_busy, if0.tx_data_ready); end
        dn = int'(if0.tx_done);
        repeat (3) begin @(negedge clk); dn += int'(if0.tx_done); end
        rst_n = 1'b1;
        capture(0, 1, 150);
        bad = 0;
        for (int j = 1; j <= 150; j++) begin
            dn += int'(rec_done[j]);
            if (rec_pin[j] !== 1'b1) bad++;
        end
        n_cmp++; if (dn != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses want 0", dn); end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rmid_line_idle: got %0d low clocks want 0", bad); end
        if0.tx_data = 8'h5A; if0.tx_data_valid = 1'b1;
        @(negedge clk);
        if0.tx_data_valid = 1'b0;
        capture(0, 1, 110);
        for (int c = 0; c < 10; c++) begin
            bad = 0;
            for (int s = 0; s < 10; s++) if (rec_pin[2 + 10*c + s] !== fb[c]) bad++;
            n_cmp++;
            if (bad != 0) begin n_fail++; $display("FAIL rmid_next_bit%0d: got %b want %b (%0d clocks wrong)", c, rec_pin[2 + 10*c + 5], fb[c], bad); end
        end
        n_cmp++; if (rec_done[101] !== 1'b1) begin n_fail++; $display("FAIL rmid_next_done: got %b want 1", rec_done[101]); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        if0.tx_data = '0; if0.tx_data_valid = 1'b0; if0.tx_break = 1'b0;
        if1.tx_data = '0; if1.tx_data_valid = 1'b0; if1.tx_break = 1'b0;
        if2.tx_data = '0; if2.tx_data_valid = 1'b0; if2.tx_break = 1'b0;
        if3.tx_data = '0; if3.tx_data_valid = 1'b0; if3.tx_break = 1'b0;

        test_reset();
        test_8n1();
        test_7o2();
        test_back_to_back();
        test_fifo_full();
        test_break();
        test_reset_mid_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
